aes_encryption_iter: RTL and testbench

//  Iterative AES-128 encryptor, the forward-direction counterpart of the decryption top.

---
 rtl/aes_encryption_iter.sv | 166 ++++++++++++++++
 tb/tb_aes_encryption_iter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encryption_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// Define AES_ENC_ROUND_TAP_EN to expose round_state/round_num debug taps.

module aes_sbox (
  input  logic [7:0] in,
  output logic [7:0] out
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so the bit offset is (255 - in) * 8.
  logic [10:0] base;
  assign base = {~in, 3'b000};
  assign out  = SBOX[base +: 8];
endmodule

module aes_encryption_iter #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [KEY_W-1:0] key,
  input  logic [KEY_W-1:0] plaintext,
  output logic [KEY_W-1:0] ciphertextout,
  output logic             busy,
  output logic             done
`ifdef AES_ENC_ROUND_TAP_EN
  ,
  output logic [127:0]     round_state,
  output logic [3:0]       round_num
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_next;
  logic [127:0] st, rk, nrk;
  logic [127:0] sub_bytes, shifted, mixed, round_out;
  logic [31:0]  rot_word, sub_word, key_temp, w0, w1, w2, w3;
  logic [3:0]   round;
  logic [7:0]   rcon;
  logic         last_round;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    aes_sbox u_sbox (.in(st[127-8*i -: 8]), .out(sub_bytes[127-8*i -: 8]));
  end

  for (genvar i = 0; i < 4; i++) begin : g_sub_word
    aes_sbox u_sbox (.in(rot_word[31-8*i -: 8]), .out(sub_word[31-8*i -: 8]));
  end

  assign last_round = (round == 4'(NR));
  assign rot_word   = {rk[23:0], rk[31:24]};
  assign key_temp   = sub_word ^ {rcon, 24'h0};
  assign w0         = rk[127:96] ^ key_temp;
  assign w1         = rk[95:64]  ^ w0;
  assign w2         = rk[63:32]  ^ w1;
  assign w3         = rk[31:0]   ^ w2;
  assign nrk        = {w0, w1, w2, w3};

  // Byte n of the block is row n%4 of column n/4; row r rotates left by r columns.
  always_comb begin
    shifted = '0;
    mixed   = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
    end
    round_out = (last_round ? shifted : mixed) ^ nrk;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (enable) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_round) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // round saturates at NR on the final edge and is cleared on the way back to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st            <= '0;
      rk            <= '0;
      round         <= '0;
      rcon          <= 8'h01;
      ciphertextout <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            st    <= plaintext ^ key;
            rk    <= key;
            round <= 4'd1;
            rcon  <= 8'h01;
          end
        end
        RUN: begin
          st   <= round_out;
          rk   <= nrk;
          rcon <= xtime(rcon);
          if (last_round) ciphertextout <= round_out;
          else            round         <= round + 4'd1;
        end
        DONE:    round <= '0;
        default: ;
      endcase
    end
  end

`ifdef AES_ENC_ROUND_TAP_EN
  assign round_state = (state == IDLE) ? '0 : st;
  assign round_num   = (state == DONE) ? round :
                       (state == RUN)  ? round - 4'd1 : 4'd0;
`endif
endmodule

// File: tb/tb_aes_encryption_iter.sv
// Self-checking bench for aes_encryption_iter: FIPS-197 vectors, handshake corner cases
// and random blocks checked against a byte-level AES-128 reference model.
module tb_aes_encryption_iter;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst, enable, busy, done;
  logic [127:0] key, plaintext, ciphertextout;
`ifdef AES_ENC_ROUND_TAP_EN
  logic [127:0] round_state;
  logic [3:0]   round_num;
`endif

  aes_encryption_iter dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .key(key),
    .plaintext(plaintext),
    .ciphertextout(ciphertextout),
    .busy(busy),
    .done(done)
`ifdef AES_ENC_ROUND_TAP_EN
    ,
    .round_state(round_state),
    .round_num(round_num)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sbox_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
  task automatic initSbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      b = inv;
      sbox_tab[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                      ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  // State after nr full rounds (nr=10 gives the ciphertext).
  function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] p,
                                               input int nr);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [31:0]  tmp;
    logic [7:0]   rc = 8'h01;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]],
               sbox_tab[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int row = 0; row < 4; row++) a[row] = s[4*c+row];
          for (int row = 0; row < 4; row++)
            s[4*c+row] = gmul(a[row], 8'h02) ^ gmul(a[(row+1)%4], 8'h03)
                         ^ a[(row+2)%4] ^ a[(row+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge E.
  task automatic applyStimulus(input logic [127:0] k, input logic [127:0] p);
    key       = k;
    plaintext = p;
    enable    = 1'b1;
    @(negedge clk);
    enable    = 1'b0;
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic runVector(input string tag, input logic [127:0] k, input logic [127:0] p,
                           input logic [127:0] exp);
    int n;
    applyStimulus(k, p);
    checkOutput({tag, "_busy_start"}, 128'(busy), 128'(1));
    waitDone(n);
    checkOutput({tag, "_latency"}, 128'(n), 128'(10));
    checkOutput({tag, "_ct"}, ciphertextout, exp);
    checkOutput({tag, "_busy_done"}, 128'(busy), 128'(1));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 128'({busy, done}), 128'(0));
  endtask

  initial begin
    int           n, m, done_cnt, done_at, busy_low;
    logic [127:0] ct_seen, rk_v, rp_v;

    initSbox();
    rst = 1'b0; enable = 1'b0; key = '0; plaintext = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ct", ciphertextout, '0);
    checkOutput("reset_busy_done", 128'({busy, done}), 128'(0));
`ifdef AES_ENC_ROUND_TAP_EN
    checkOutput("reset_tap", {round_state[123:0], round_num}, '0);
`endif
    rst = 1'b1;
    @(negedge clk);

    runVector("fips_b", K1, P1, C1);
    checkOutput("fips_b_model", ciphertextout, ref_encrypt(K1, P1, 10));
    runVector("fips_c1", K2, P2, C2);
    runVector("zero", '0, '0, CZ);

`ifdef AES_ENC_ROUND_TAP_EN
    applyStimulus(K1, P1);
    checkOutput("tap_round0", 128'(round_num), 128'(0));
    for (int r = 1; r <= 10; r++) begin
      @(negedge clk);
      checkOutput($sformatf("tap_num%0d", r), 128'(round_num), 128'(r));
      checkOutput($sformatf("tap_state%0d", r), round_state, ref_encrypt(K1, P1, r));
      if (r == 1) checkOutput("tap_fips_r1", round_state, 128'ha49c7ff2689f352b6b5bea43026a5049);
    end
    checkOutput("tap_done", 128'(done), 128'(1));
    @(negedge clk);
    checkOutput("tap_idle", {round_state[123:0], round_num}, '0);
`endif

    // Extra enable pulses while busy must be dropped, not queued.
    applyStimulus(K1, P1);
    done_cnt = 0; done_at = 0; busy_low = 0; ct_seen = '0;
    for (int c = 1; c <= 25; c++) begin
      if (c == 3 || c == 7) begin
        enable = 1'b1; key = K2; plaintext = P2;
      end else begin
        enable = 1'b0;
      end
      @(negedge clk);
      if (c <= 10 && busy !== 1'b1) busy_low++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) begin done_at = c; ct_seen = ciphertextout; end
      end
    end
    checkOutput("pulse_busy_low", 128'(busy_low), 128'(0));
    checkOutput("pulse_done_at", 128'(done_at), 128'(10));
    checkOutput("pulse_done_cnt", 128'(done_cnt), 128'(1));
    checkOutput("pulse_ct", ct_seen, C1);

    // Enable held high: back-to-back results 12 cycles apart, key sampled only at accept.
    key = K1; plaintext = P1; enable = 1'b1;
    @(negedge clk);
    key = K2; plaintext = P2;
    waitDone(n);
    checkOutput("hold_latency1", 128'(n), 128'(10));
    checkOutput("hold_ct1", ciphertextout, C1);
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (done !== 1'b1 && m < 40);
    enable = 1'b0;
    checkOutput("hold_spacing", 128'(m), 128'(12));
    checkOutput("hold_ct2", ciphertextout, C2);
    repeat (2) @(negedge clk);
    checkOutput("hold_idle", 128'({busy, done}), 128'(0));

    // Reset mid-run aborts without a done and clears the result.
    applyStimulus(K1, P1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_ct", ciphertextout, '0);
    checkOutput("abort_busy_done", 128'({busy, done}), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    checkOutput("abort_no_done", 128'(done_cnt), 128'(0));
    runVector("after_abort", K2, P2, C2);

    for (int i = 0; i < 6; i++) begin
      rk_v = {$urandom, $urandom, $urandom, $urandom};
      rp_v = {$urandom, $urandom, $urandom, $urandom};
      runVector($sformatf("rand%0d", i), rk_v, rp_v, ref_encrypt(rk_v, rp_v, 10));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
